// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and helpers used by the conv and pooling stages.
// Pixels are signed fixed point; after ReLU they are compared as unsigned.
package cnn_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 12;

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  function automatic pixel_t relu(input pixel_t x);
    return x[DATA_WIDTH-1] ? '0 : x;
  endfunction

  function automatic pixel_t max2(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/relu_maxpool_if.sv
// Pixel stream from the conv layer into the pooling stage, and the pooled stream out.
interface relu_maxpool_if #(
  parameter int data_width = cnn_pkg::DATA_WIDTH
);

  logic [data_width-1:0] i_data;
  logic                  i_valid;
  logic                  i_end;
  logic [data_width-1:0] o_data;
  logic                  o_valid;
  logic                  o_end;
  logic                  o_frame_err;

  modport master (
    output i_data, i_valid, i_end,
    input  o_data, o_valid, o_end, o_frame_err
  );

  modport slave (
    input  i_data, i_valid, i_end,
    output o_data, o_valid, o_end, o_frame_err
  );

endinterface

// File: rtl/relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max pooling on a raster-order pixel stream,
// using one hold register and one row buffer of partial (top-row) maxima.
module relu_maxpool
  import cnn_pkg::*;
#(
  parameter int in_size    = 7,
  parameter int data_width = DATA_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  relu_maxpool_if.slave  bus
);

  localparam int out_size = in_size / 2;
  localparam int pool_lim = 2 * out_size;
  // Extra counter bit so pool_lim itself is representable for even in_size.
  localparam int cw = $clog2(in_size + 1);
  localparam int iw = (out_size > 1) ? $clog2(out_size) : 1;

  logic [cw-1:0]         col;
  logic [cw-1:0]         row;
  logic [data_width-1:0] hold;
  logic [data_width-1:0] x;
  logic [data_width-1:0] pair_max;
  logic [data_width-1:0] rowbuf [out_size];
  logic [iw-1:0]         slot;
  logic                  col_last;
  logic                  row_last;
  logic                  early_end;
  logic                  in_pool;

  always_comb begin
    x         = relu(bus.i_data);
    pair_max  = max2(hold, x);
    slot      = iw'(col >> 1);
    col_last  = (col == cw'(in_size - 1));
    row_last  = (row == cw'(in_size - 1));
    early_end = bus.i_end && !(col_last && row_last);
    in_pool   = (col < cw'(pool_lim)) && (row < cw'(pool_lim));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col             <= '0;
      row             <= '0;
      hold            <= '0;
      bus.o_data      <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_end       <= 1'b0;
      bus.o_frame_err <= 1'b0;
    end else begin
      bus.o_valid     <= 1'b0;
      bus.o_end       <= 1'b0;
      bus.o_frame_err <= 1'b0;
      if (bus.i_valid) begin
        if (early_end) begin
          // A short frame resynchronises to (0,0) and drops this beat entirely.
          col             <= '0;
          row             <= '0;
          bus.o_frame_err <= 1'b1;
        end else begin
          if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
          if (in_pool) begin
            if (!col[0]) begin
              hold <= x;
            end else if (row[0]) begin
              bus.o_data  <= max2(rowbuf[slot], pair_max);
              bus.o_valid <= 1'b1;
              bus.o_end   <= (row == cw'(pool_lim - 1)) && (col == cw'(pool_lim - 1));
            end
          end
        end
      end
    end
  end

  // Row buffer carries the top-row pair maxima down to the odd row; never reset.
  always_ff @(posedge clk) begin
    if (!rst && bus.i_valid && !early_end && in_pool && col[0] && !row[0]) begin
      rowbuf[slot] <= pair_max;
    end
  end

endmodule
